// File: rtl/domain_cfg_sync_if.sv
// domain_cfg_sync_if: config inputs and published outputs of domain_cfg_sync.
// Glitch-counter signals exist only when DOMAIN_CFG_SYNC_GLITCH_CNT_EN is defined.
interface domain_cfg_sync_if #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 8
);
   logic [NUM_CH*WIDTH-1:0] cfg_i;
   logic [NUM_CH*WIDTH-1:0] cfg_o;
   logic [NUM_CH-1:0]       cfg_valid_o;
   logic [NUM_CH-1:0]       cfg_chg_o;
   logic                    domain_rst_n_o;
   logic                    busy_o;
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
   logic [NUM_CH*8-1:0]     glitch_cnt_o;
   logic                    glitch_clr_i;
   modport master (output cfg_i, glitch_clr_i,
                   input  cfg_o, cfg_valid_o, cfg_chg_o, domain_rst_n_o, busy_o, glitch_cnt_o);
   modport slave  (input  cfg_i, glitch_clr_i,
                   output cfg_o, cfg_valid_o, cfg_chg_o, domain_rst_n_o, busy_o, glitch_cnt_o);
`else
   modport master (output cfg_i,
                   input  cfg_o, cfg_valid_o, cfg_chg_o, domain_rst_n_o, busy_o);
   modport slave  (input  cfg_i,
                   output cfg_o, cfg_valid_o, cfg_chg_o, domain_rst_n_o, busy_o);
`endif
endinterface

// File: rtl/domain_cfg_sync.sv
// domain_cfg_sync: synchronises and stability-filters NUM_CH config words, then sequences a domain reset.
// Define DOMAIN_CFG_SYNC_GLITCH_CNT_EN to add per-channel rejected-glitch counters.
module domain_cfg_sync #(
   parameter int NUM_CH           = 2,
   parameter int WIDTH            = 8,
   parameter int SYNC_STAGES      = 2,
   parameter int STABLE_CYCLES    = 4,
   parameter int RST_HOLD_CYCLES  = 8,
   parameter int RESYNC_ON_CHANGE = 0
) (
   input logic              clk_i,
   input logic              reset_n_i,
   domain_cfg_sync_if.slave bus
);
   localparam int NW = NUM_CH*WIDTH;
   localparam int CW = $clog2(STABLE_CYCLES+1);
   localparam int HW = RST_HOLD_CYCLES > 1 ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES-1);
   localparam logic [1:0] S_HOLD = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2;

   logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
   logic [NW-1:0]     cfg_w;
   logic [NUM_CH-1:0] valid_w, chg_w;
   logic [1:0]        state, state_nx;
   logic [HW-1:0]     hcnt;
   logic              rst_q, busy_q, resync;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cfg_i};

`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
   logic [NUM_CH*8-1:0] glitch_w;
   assign bus.glitch_cnt_o = glitch_w;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [WIDTH-1:0] sync_w, cand, pub;
      logic [CW-1:0]    cnt;
      logic             vld, chg, reload, publish;
      assign sync_w  = sync_q[SYNC_STAGES-1][k*WIDTH +: WIDTH];
      assign reload  = sync_w != cand;
      // First publish happens even when the stable value equals the reset value of cfg_o
      assign publish = cnt == CNT_MAX && (pub != cand || !vld);
      always_ff @(posedge clk_i or negedge reset_n_i)
         if (!reset_n_i) begin
            cand <= '0;
            cnt  <= '0;
            pub  <= '0;
            vld  <= 1'b0;
            chg  <= 1'b0;
         end else begin
            if (reload) begin
               cand <= sync_w;
               cnt  <= '0;
            end else if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
            if (publish) begin
               pub <= cand;
               vld <= 1'b1;
            end
            chg <= publish;
         end
      assign cfg_w[k*WIDTH +: WIDTH] = pub;
      assign valid_w[k] = vld;
      assign chg_w[k]   = chg;
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
      logic [7:0] gcnt;
      always_ff @(posedge clk_i or negedge reset_n_i)
         if (!reset_n_i) gcnt <= '0;
         else if (bus.glitch_clr_i) gcnt <= '0;
         else if (reload && cnt != '0 && cnt < CNT_MAX && gcnt != 8'hFF) gcnt <= gcnt + 8'd1;
      assign glitch_w[k*8 +: 8] = gcnt;
`endif
   end

   assign resync = RESYNC_ON_CHANGE != 0 && |chg_w;

   always_comb
      state_nx = state == S_HOLD ? (hcnt == HOLD_LAST ? S_WAIT : S_HOLD) :
                 state == S_WAIT ? (&valid_w ? S_RUN : S_WAIT) :
                 (resync ? S_HOLD : S_RUN);

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state  <= S_HOLD;
         hcnt   <= '0;
         rst_q  <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         state  <= state_nx;
         hcnt   <= (state == S_HOLD && state_nx == S_HOLD) ? hcnt + HW'(1) : '0;
         rst_q  <= state_nx == S_RUN;
         busy_q <= state_nx != S_RUN;
      end

   assign bus.cfg_o          = cfg_w;
   assign bus.cfg_valid_o    = valid_w;
   assign bus.cfg_chg_o      = chg_w;
   assign bus.domain_rst_n_o = rst_q;
   assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_domain_cfg_sync.sv
// tb_domain_cfg_sync: directed bench for domain_cfg_sync; dut0 has RESYNC_ON_CHANGE=0, dut1 has 1.
// Glitch-counter scenarios compile only with DOMAIN_CFG_SYNC_GLITCH_CNT_EN defined.
module tb_domain_cfg_sync;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   domain_cfg_sync_if #(.NUM_CH(2), .WIDTH(8)) b0 ();
   domain_cfg_sync_if #(.NUM_CH(2), .WIDTH(8)) b1 ();
   assign b1.cfg_i = b0.cfg_i;
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
   assign b1.glitch_clr_i = b0.glitch_clr_i;
`endif

   domain_cfg_sync #(.NUM_CH(2), .WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4),
                     .RST_HOLD_CYCLES(8), .RESYNC_ON_CHANGE(0))
      dut0 (.clk_i(clk), .reset_n_i(rst_n), .bus(b0.slave));
   domain_cfg_sync #(.NUM_CH(2), .WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4),
                     .RST_HOLD_CYCLES(8), .RESYNC_ON_CHANGE(1))
      dut1 (.clk_i(clk), .reset_n_i(rst_n), .bus(b1.slave));

   task automatic run_startup(input string tag);
      int t_valid, t_rise, n_chg, n_both, busy_bad, t_rise1;
      logic [1:0] rise_valid;
      t_valid = -1; t_rise = -1; t_rise1 = -1; n_chg = 0; n_both = 0; busy_bad = 0; rise_valid = 2'b00;
      rst_n = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (b0.cfg_chg_o != 2'b00) n_chg++;
         if (b0.cfg_chg_o == 2'b11) n_both++;
         if (t_valid < 0 && b0.cfg_valid_o == 2'b11) t_valid = i;
         if (t_rise < 0 && b0.domain_rst_n_o) begin
            t_rise = i;
            rise_valid = b0.cfg_valid_o;
         end
         if (t_rise1 < 0 && b1.domain_rst_n_o) t_rise1 = i;
         if (b0.busy_o !== !b0.domain_rst_n_o) busy_bad++;
      end
      checks++;
      if (t_valid !== 8) begin
         errors++;
         $display("FAIL %s_valid_time: valid at cycle %0d, expected 8", tag, t_valid);
      end
      checks++;
      if (n_chg !== 1 || n_both !== 1) begin
         errors++;
         $display("FAIL %s_chg_pulse: pulse cycles=%0d both=%0d, expected 1 and 1", tag, n_chg, n_both);
      end
      checks++;
      if (t_rise !== 9 || rise_valid !== 2'b11) begin
         errors++;
         $display("FAIL %s_rst_release: rise at %0d valid=%b, expected 9 and 11", tag, t_rise, rise_valid);
      end
      checks++;
      if (t_rise1 !== 9) begin
         errors++;
         $display("FAIL %s_rst_release_dut1: rise at %0d, expected 9", tag, t_rise1);
      end
      checks++;
      if (b0.cfg_o !== 16'h1234 || b1.cfg_o !== 16'h1234) begin
         errors++;
         $display("FAIL %s_cfg_o: dut0=%h dut1=%h, expected 1234", tag, b0.cfg_o, b1.cfg_o);
      end
      checks++;
      if (busy_bad !== 0) begin
         errors++;
         $display("FAIL %s_busy_track: %0d cycles busy_o != !domain_rst_n_o, expected 0", tag, busy_bad);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      b0.cfg_i = 16'h1234;
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
      b0.glitch_clr_i = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if ({b0.cfg_o, b0.cfg_valid_o, b0.cfg_chg_o, b0.domain_rst_n_o, b0.busy_o} !== {16'h0, 2'b00, 2'b00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: cfg=%h valid=%b chg=%b rst_n=%b busy=%b, expected 0000 00 00 0 1",
                  b0.cfg_o, b0.cfg_valid_o, b0.cfg_chg_o, b0.domain_rst_n_o, b0.busy_o);
      end
      run_startup("startup");
   endtask

   task automatic test_step_ch0();
      logic [7:0] at7, at8;
      int n0, t0, n1, ch1_bad, rst_bad;
      n0 = 0; t0 = -1; n1 = 0; ch1_bad = 0; rst_bad = 0; at7 = 8'h00; at8 = 8'h00;
      b0.cfg_i[7:0] = 8'h56;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 7) at7 = b0.cfg_o[7:0];
         if (i == 8) at8 = b0.cfg_o[7:0];
         if (b0.cfg_chg_o[0]) begin
            n0++;
            t0 = i;
         end
         if (b0.cfg_chg_o[1]) n1++;
         if (b0.cfg_o[15:8] !== 8'h12) ch1_bad++;
         if (b0.domain_rst_n_o !== 1'b1 || b0.busy_o !== 1'b0) rst_bad++;
      end
      checks++;
      if (at7 !== 8'h34 || at8 !== 8'h56) begin
         errors++;
         $display("FAIL step_latency: cfg_o[7:0] at edge7=%h edge8=%h, expected 34 then 56", at7, at8);
      end
      checks++;
      if (n0 !== 1 || t0 !== 8 || n1 !== 0) begin
         errors++;
         $display("FAIL step_chg: chg0 count=%0d at %0d chg1 count=%0d, expected 1 at 8 and 0", n0, t0, n1);
      end
      checks++;
      if (ch1_bad !== 0 || rst_bad !== 0) begin
         errors++;
         $display("FAIL step_side_effect: ch1 bad=%0d rst bad=%0d, expected 0 and 0", ch1_bad, rst_bad);
      end
   endtask

   task automatic test_glitch_ch1();
      int n_chg, ch1_bad;
      n_chg = 0; ch1_bad = 0;
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
      b0.glitch_clr_i = 1'b1;
      @(negedge clk);
      b0.glitch_clr_i = 1'b0;
`endif
      b0.cfg_i[15:8] = 8'hFF;
      repeat (3) @(negedge clk);
      b0.cfg_i[15:8] = 8'h12;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (b0.cfg_chg_o !== 2'b00) n_chg++;
         if (b0.cfg_o[15:8] !== 8'h12) ch1_bad++;
      end
      checks++;
      if (n_chg !== 0) begin
         errors++;
         $display("FAIL glitch_no_chg: %0d pulse cycles, expected 0", n_chg);
      end
      checks++;
      if (ch1_bad !== 0 || b0.cfg_o !== 16'h1256) begin
         errors++;
         $display("FAIL glitch_hold: cfg_o=%h bad cycles=%0d, expected 1256 and 0", b0.cfg_o, ch1_bad);
      end
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
      checks++;
      if (b0.glitch_cnt_o !== 16'h0100) begin
         errors++;
         $display("FAIL glitch_count: glitch_cnt_o=%h, expected 0100", b0.glitch_cnt_o);
      end
`endif
   endtask

   task automatic test_resync();
      int t_run, t_chg, t_fall, t_rise, busy_bad, rst0_bad;
      t_run = -1; t_chg = -1; t_fall = -1; t_rise = -1; busy_bad = 0; rst0_bad = 0;
      for (int i = 0; i < 50 && t_run < 0; i++) begin
         @(negedge clk);
         if (!b1.busy_o) t_run = i;
      end
      checks++;
      if (t_run < 0) begin
         errors++;
         $display("FAIL resync_ready: dut1 busy_o=%b after 50 cycles, expected 0", b1.busy_o);
      end
      b0.cfg_i[15:8] = 8'h99;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (t_chg < 0 && b1.cfg_chg_o[1]) t_chg = i;
         if (t_fall < 0 && !b1.domain_rst_n_o) t_fall = i;
         if (t_fall > 0 && t_rise < 0 && b1.domain_rst_n_o) t_rise = i;
         if (b1.busy_o !== !b1.domain_rst_n_o) busy_bad++;
         if (b0.domain_rst_n_o !== 1'b1) rst0_bad++;
      end
      checks++;
      if (t_chg !== 8 || t_fall !== 9) begin
         errors++;
         $display("FAIL resync_fall: chg at %0d rst low at %0d, expected 8 and 9", t_chg, t_fall);
      end
      checks++;
      if (t_rise !== t_fall + 9) begin
         errors++;
         $display("FAIL resync_hold: rst high again at %0d fall %0d, expected fall+9", t_rise, t_fall);
      end
      checks++;
      if (busy_bad !== 0 || rst0_bad !== 0 || b0.cfg_o !== 16'h9956) begin
         errors++;
         $display("FAIL resync_side: busy bad=%0d dut0 rst bad=%0d cfg_o=%h, expected 0 0 9956",
                  busy_bad, rst0_bad, b0.cfg_o);
      end
   endtask

`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
   task automatic test_glitch_sat();
      int n_chg;
      n_chg = 0;
      for (int n = 0; n < 302; n++) begin
         b0.cfg_i[7:0] = n[0] ? 8'h56 : 8'h00;
         repeat (2) begin
            @(negedge clk);
            if (b0.cfg_chg_o[0]) n_chg++;
         end
      end
      repeat (12) begin
         @(negedge clk);
         if (b0.cfg_chg_o[0]) n_chg++;
      end
      checks++;
      if (b0.glitch_cnt_o[7:0] !== 8'hFF || n_chg !== 0 || b0.cfg_o[7:0] !== 8'h56) begin
         errors++;
         $display("FAIL glitch_saturate: cnt=%h chg=%0d cfg=%h, expected ff 0 56",
                  b0.glitch_cnt_o[7:0], n_chg, b0.cfg_o[7:0]);
      end
      b0.glitch_clr_i = 1'b1;
      @(negedge clk);
      b0.glitch_clr_i = 1'b0;
      checks++;
      if (b0.glitch_cnt_o !== 16'h0000) begin
         errors++;
         $display("FAIL glitch_clear: glitch_cnt_o=%h, expected 0000", b0.glitch_cnt_o);
      end
   endtask
`endif

   task automatic test_mid_reset();
      b0.cfg_i[7:0] = 8'hAB;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({b0.cfg_o, b0.cfg_valid_o, b0.cfg_chg_o, b0.domain_rst_n_o, b0.busy_o} !== {16'h0, 2'b00, 2'b00, 1'b0, 1'b1} ||
          {b1.cfg_o, b1.cfg_valid_o, b1.domain_rst_n_o, b1.busy_o} !== {16'h0, 2'b00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_async: cfg=%h valid=%b chg=%b rst_n=%b busy=%b, expected 0000 00 00 0 1",
                  b0.cfg_o, b0.cfg_valid_o, b0.cfg_chg_o, b0.domain_rst_n_o, b0.busy_o);
      end
      b0.cfg_i = 16'h1234;
      repeat (2) @(negedge clk);
      run_startup("restart");
   endtask

   initial begin
      test_reset();
      test_step_ch0();
      test_glitch_ch1();
      test_resync();
`ifdef DOMAIN_CFG_SYNC_GLITCH_CNT_EN
      test_glitch_sat();
`endif
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
